// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI frame engine between N_REQ requesters.
// Latches the winner's word, issues START, waits for engine done, then enforces a CS-high gap.
module spi_frame_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]     req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            done_o,
    output logic                        eng_start_o,
    output logic [DATA_W-1:0]           eng_data_o,
    input  logic                        eng_done_i,
    output logic [N_REQ-1:0]            cs_sel_o,
    output logic [$clog2(N_REQ)-1:0]    grant_id_o,
    output logic                        busy_o
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = 4;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       gid_q, gid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    cs_q, cs_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                win_found;
    logic [GW-1:0]       win_idx;

    // Rotating search starting just after the last owner.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr_q) + i) % N_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && win_found) ? (ONE << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = '0;
        cs_d    = cs_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = START;
                    ptr_d   = win_idx;
                    gid_d   = win_idx;
                    data_d  = req_data_i[win_idx*DATA_W +: DATA_W];
                    start_d = 1'b1;
                    cs_d    = ONE << win_idx;
                    busy_d  = 1'b1;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (eng_done_i) begin
                    done_d = ONE << gid_q;
                    cs_d   = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cs_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            ptr_q   <= GW'(N_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            cs_q    <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done_o      = done_q;
    assign eng_start_o = start_q;
    assign eng_data_o  = data_q;
    assign cs_sel_o    = cs_q;
    assign grant_id_o  = gid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter: cycle table plus hand sequences for long frames,
// round-robin order, partial contention and mid-frame reset.
module tb_spi_frame_arbiter;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic [3:0]  req_valid_i = '0;
    logic [63:0] req_data_i = '0;
    logic [3:0]  req_ready_o;
    logic [3:0]  done_o;
    logic        eng_start_o;
    logic [15:0] eng_data_o;
    logic        eng_done_i = 1'b0;
    logic [3:0]  cs_sel_o;
    logic [1:0]  grant_id_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    spi_frame_arbiter #(
        .N_REQ(4),
        .DATA_W(16),
        .GAP_CYCLES(2)
    ) dut (
        .clk_i(clk_i),
        .arst_ni(arst_ni),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .done_o(done_o),
        .eng_start_o(eng_start_o),
        .eng_data_o(eng_data_o),
        .eng_done_i(eng_done_i),
        .cs_sel_o(cs_sel_o),
        .grant_id_o(grant_id_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic        ed;
        logic [3:0]  rdy;
        logic        st;
        logic [3:0]  dn;
        logic [3:0]  cs;
        logic [1:0]  gid;
        logic        bsy;
        logic [15:0] dat;
    } vec_t;

    vec_t tbl[13];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {req_ready_o, eng_start_o, done_o, cs_sel_o, grant_id_o, busy_o, eng_data_o};
    endfunction

    task automatic do_reset();
        arst_ni     = 1'b0;
        req_valid_i = '0;
        eng_done_i  = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        arst_ni = 1'b1;
        tick();
    endtask

    // Waits for an accept, then plays an engine that finishes 2 cycles after START.
    task automatic run_frame(input logic [3:0] v, output int gid);
        int n;
        gid         = -1;
        req_valid_i = v;
        n           = 0;
        #1;
        while (req_ready_o == 4'b0 && n < 50) begin
            tick();
            n++;
        end
        if (req_ready_o == 4'b0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no ready after %0d cycles, want ready", n);
        end else begin
            for (int k = 0; k < 4; k++)
                if (req_ready_o[k]) gid = k;
            tick();
            chk("rf_start", {63'b0, eng_start_o}, 64'd1);
            tick();
            tick();
            eng_done_i = 1'b1;
            tick();
            eng_done_i = 1'b0;
            chk("rf_done", {60'b0, done_o}, 64'(4'b0001 << gid));
        end
    endtask

    initial begin
        int g;
        int n;

        //  v        data                   ed   rdy      st  dn       cs       gid  bsy  dat
        tbl[0]  = '{4'b0000, 64'h0,                 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{4'b0100, 64'h0000_A5C3_0000_0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[2]  = '{4'b0000, 64'h0000_FFFF_0000_0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'hA5C3};
        tbl[3]  = '{4'b0001, 64'h0000_FFFF_0000_0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'hA5C3};
        tbl[4]  = '{4'b0001, 64'h0000_FFFF_0000_0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'hA5C3};
        tbl[5]  = '{4'b0001, 64'h0000_FFFF_0000_0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, 16'hA5C3};
        tbl[6]  = '{4'b0001, 64'h0000_FFFF_0000_0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 16'hA5C3};
        tbl[7]  = '{4'b0001, 64'h0000_FFFF_0000_1234, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'hA5C3};
        tbl[8]  = '{4'b0000, 64'h0000_FFFF_0000_9999, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1234};
        tbl[9]  = '{4'b0000, 64'h0,                 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1234};
        tbl[10] = '{4'b0000, 64'h0,                 1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 16'h1234};
        tbl[11] = '{4'b0000, 64'h0,                 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 16'h1234};
        tbl[12] = '{4'b0000, 64'h0,                 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h1234};

        // Reset defaults
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("reset_idle_%0d", i), {32'b0, outs()}, 64'h0);
            tick();
        end

        // Table: single frame with data change after accept, busy offers, spurious done
        for (int i = 0; i < 13; i++) begin
            req_valid_i = tbl[i].v;
            req_data_i  = tbl[i].d;
            eng_done_i  = tbl[i].ed;
            #1;
            chk($sformatf("row_%0d", i), {32'b0, outs()},
                {32'b0, tbl[i].rdy, tbl[i].st, tbl[i].dn, tbl[i].cs, tbl[i].gid, tbl[i].bsy, tbl[i].dat});
            tick();
        end
        eng_done_i = 1'b0;

        // Single frame, engine done 40 cycles after START
        req_valid_i = 4'b0100;
        req_data_i  = 64'h0000_A5C3_0000_0000;
        #1;
        chk("sf_ready", {60'b0, req_ready_o}, 64'h4);
        tick();
        chk("sf_start", {43'b0, eng_start_o, eng_data_o, cs_sel_o}, {43'b0, 1'b1, 16'hA5C3, 4'b0100});
        for (int i = 0; i < 40; i++) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        chk("sf_done", {56'b0, done_o, req_ready_o}, {56'b0, 4'b0100, 4'b0000});
        n = 0;
        while (req_ready_o == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("sf_gap_spacing", 64'(n), 64'd2);
        req_valid_i = 4'b0000;

        // Round-robin fairness
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_frame(4'b1111, g);
            chk($sformatf("rr_grant_%0d", i), 64'(g), 64'(i % 4));
        end

        // Partial contention
        run_frame(4'b1000, g);
        chk("pc_grant3", 64'(g), 64'd3);
        run_frame(4'b1010, g);
        chk("pc_grant1", 64'(g), 64'd1);
        run_frame(4'b1010, g);
        chk("pc_grant3b", 64'(g), 64'd3);

        // Reset mid-frame
        req_valid_i = 4'b0100;
        n = 0;
        #1;
        while (req_ready_o == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("mr_ready", {60'b0, req_ready_o}, 64'h4);
        tick();
        req_valid_i = 4'b0000;
        tick();
        chk("mr_in_wait", {59'b0, busy_o, cs_sel_o}, {59'b0, 1'b1, 4'b0100});
        #2;
        arst_ni = 1'b0;
        #1;
        chk("mr_async_reset", {32'b0, outs()}, 64'h0);
        eng_done_i = 1'b1;
        tick();
        @(negedge clk_i);
        arst_ni    = 1'b1;
        eng_done_i = 1'b0;
        tick();
        chk("mr_no_done", {59'b0, done_o, busy_o}, 64'h0);
        req_valid_i = 4'b1111;
        #1;
        chk("mr_req0_first", {60'b0, req_ready_o}, 64'h1);
        req_valid_i = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
